// File: rtl/product_bcd_display_pkg.sv
// Shared types and constants for the product BCD display stage.
package product_bcd_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  // Blank digit, active-low {g..a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g..a} patterns for decimal digits 0-9
  localparam logic [6:0] SEG_PATTERNS [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Smallest digit count whose decimal range covers 2^width-1
  function automatic int unsigned bcd_min_digits(input int unsigned width);
    longint unsigned max_val;
    longint unsigned pow10;
    int unsigned     digits;
    max_val = (64'd1 << width) - 64'd1;
    pow10   = 64'd1;
    digits  = 0;
    while (pow10 <= max_val) begin
      pow10  = pow10 * 64'd10;
      digits = digits + 1;
    end
    return digits;
  endfunction

endpackage

// File: rtl/product_bcd_display_seg7_decode.sv
// One BCD digit to active-low seven-segment pattern, with blanking.
module product_bcd_display_seg7_decode
  import product_bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Decode the digit; blank on request or for non-decimal nibbles
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (bcd_i <= 4'd9)) begin
      seg_o = SEG_PATTERNS[bcd_i];
    end
  end

endmodule

// File: rtl/product_bcd_display.sv
// Sequential double-dabble converter: watches the product bus and converts
// every new value to DIGITS BCD digits over WIDTH shift cycles.
// Optional macro SEG_DECODE_EN adds registered seven-segment outputs with
// leading-zero blanking.
module product_bcd_display
  import product_bcd_display_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      prod_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done
`ifdef SEG_DECODE_EN
  ,
  output logic [7*DIGITS-1:0]   seg_out
`endif
);

  localparam int unsigned SrW  = 4 * DIGITS + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (DIGITS < bcd_min_digits(WIDTH)) begin : g_digits_check
    $error("product_bcd_display: DIGITS too small to hold 2^WIDTH-1");
  end

  state_e                state_q, state_d;
  logic [SrW-1:0]        sr_q, sr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]      last_q, last_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  done_q, done_d;
  logic [SrW-1:0]        adj;

  // Next-state: capture on change, add-3/shift in CONV, publish in DONE
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;

    adj = sr_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (adj[WIDTH + 4*k +: 4] >= 4'd5) begin
        adj[WIDTH + 4*k +: 4] = adj[WIDTH + 4*k +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (prod_in != last_q) begin
          sr_d    = {{(4*DIGITS){1'b0}}, prod_in};
          last_d  = prod_in;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        sr_d  = adj << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = sr_q[WIDTH +: 4*DIGITS];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign bcd_out = bcd_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);

`ifdef SEG_DECODE_EN
  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg_dec, seg_q;

  // Blank a digit when it and all higher digits are zero; digit 0 always shows
  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      zero_run = zero_run && (sr_q[WIDTH + 4*(DIGITS-1-i) +: 4] == 4'd0);
      blank[DIGITS-1-i] = zero_run && ((DIGITS - 1 - i) != 0);
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    product_bcd_display_seg7_decode u_dec (
      .bcd_i   (sr_q[WIDTH + 4*k +: 4]),
      .blank_i (blank[k]),
      .seg_o   (seg_dec[7*k +: 7])
    );
  end

  // Segments load on the same edge as bcd_out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        seg_q[7*k +: 7] <= (k == 0) ? SEG_PATTERNS[0] : SEG_BLANK;
      end
    end else if (state_q == StDone) begin
      seg_q <= seg_dec;
    end
  end

  assign seg_out = seg_q;
`endif

endmodule

// File: tb/tb_product_bcd_display.sv
// Scoreboard bench for product_bcd_display; define SEG_DECODE_EN to also
// check the segment outputs.
module tb_product_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  prod_in;
  logic [11:0] bcd_out;
  logic        busy;
  logic        done;
`ifdef SEG_DECODE_EN
  logic [20:0] seg_out;
`endif

  product_bcd_display #(.WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .prod_in (prod_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done)
`ifdef SEG_DECODE_EN
    ,
    .seg_out (seg_out)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  logic [11:0] exp_q[$];
  logic [11:0] disp = 12'h000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

`ifdef SEG_DECODE_EN
  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [20:0] seg_model(input logic [11:0] b);
    logic bl2, bl1;
    bl2 = (b[11:8] == 4'd0);
    bl1 = bl2 && (b[7:4] == 4'd0);
    return {bl2 ? 7'h7F : seg_pat(b[11:8]), bl1 ? 7'h7F : seg_pat(b[7:4]),
            seg_pat(b[3:0])};
  endfunction
`endif

  // Scoreboard monitor: pop on done, otherwise bcd_out must hold
  always @(negedge clk) begin : mon
    logic [11:0] e;
    if (rst) begin
      disp = 12'h000;
    end else if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("bcd", {20'd0, bcd_out}, {20'd0, e});
        check("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef SEG_DECODE_EN
        check("seg", {11'd0, seg_out}, {11'd0, seg_model(e)});
`endif
        disp = e;
      end
    end else if (bcd_out !== disp) begin
      check("bcd_stable", {20'd0, bcd_out}, {20'd0, disp});
    end
  end

  task automatic drive(input int v);
    @(posedge clk);
    #1 prod_in = 8'(v);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("idle_timeout", {31'd0, busy}, 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    int cur;
    int v;

    // Reset with zero input: nothing should ever convert
    rst = 1'b1;
    prod_in = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_bcd", {20'd0, bcd_out}, 32'h000);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef SEG_DECODE_EN
    check("rst_seg", {11'd0, seg_out}, {11'd0, 7'h7F, 7'h7F, 7'h40});
`endif
    n0 = n_done;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end
    check("zero_no_done", n_done - n0, 0);

    // 225: busy next cycle, WIDTH+1 edges to result
    drive(225);
    exp_q.push_back(to_bcd(225));
    @(negedge clk);
    check("busy_pre", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("busy_rise", {31'd0, busy}, 32'd1);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, 9);
    wait_idle(40);
    @(negedge clk);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("bcd_225", {20'd0, bcd_out}, 32'h225);

    // 99 then 45 mid-conversion: both converted, in order
    n0 = n_done;
    drive(99);
    exp_q.push_back(to_bcd(99));
    repeat (2) @(posedge clk);
    drive(45);
    exp_q.push_back(to_bcd(45));
    wait_idle(60);
    check("two_dones", n_done - n0, 2);

    // Reset mid-conversion discards the partial result
    n0 = n_done;
    drive(200);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_bcd", {20'd0, bcd_out}, 32'h000);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_done", n_done - n0, 0);
    exp_q.push_back(to_bcd(200));
    rst = 1'b0;
    wait_idle(40);
    check("bcd_200", {20'd0, bcd_out}, 32'h200);
    check("after_abort_dones", n_done - n0, 1);

    // 7 -> 8 -> 7 inside one conversion: single result
    @(posedge clk);
    #1 rst = 1'b1;
    prod_in = 8'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    n0 = n_done;
    drive(7);
    exp_q.push_back(to_bcd(7));
    repeat (2) @(posedge clk);
    drive(8);
    repeat (2) @(posedge clk);
    drive(7);
    wait_idle(40);
    repeat (20) @(negedge clk);
    check("toggle_dones", n_done - n0, 1);
    check("toggle_busy", {31'd0, busy}, 32'd0);
    check("bcd_007", {20'd0, bcd_out}, 32'h007);
`ifdef SEG_DECODE_EN
    check("seg_007", {11'd0, seg_out}, {11'd0, 7'h7F, 7'h7F, 7'h78});
`endif

    // 105 exercises an interior zero digit
    drive(105);
    exp_q.push_back(to_bcd(105));
    wait_idle(40);
    check("bcd_105", {20'd0, bcd_out}, 32'h105);
`ifdef SEG_DECODE_EN
    check("seg_105", {11'd0, seg_out}, {11'd0, 7'h79, 7'h40, 7'h12});
`endif

    // Full-scale and back to zero
    drive(255);
    exp_q.push_back(to_bcd(255));
    wait_idle(40);
    check("bcd_255", {20'd0, bcd_out}, 32'h255);
    drive(0);
    exp_q.push_back(to_bcd(0));
    wait_idle(40);
    check("bcd_000", {20'd0, bcd_out}, 32'h000);

    // Random values, each different from the previous
    cur = 0;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 255));
      if (v == cur) v = v ^ 1;
      cur = v;
      drive(v);
      exp_q.push_back(to_bcd(v));
      wait_idle(40);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
